// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/response bus of the load/store unit
//
// Purpose: carries one word-wide request (address, write data, byte enables,
//   direction) from the load/store unit to data memory and the completion
//   handshake back.
// Signals:
//   mem_req    LSU -> mem  request, held until mem_ack or abort
//   mem_we     LSU -> mem  1 = write
//   mem_addr   LSU -> mem  word-aligned address
//   mem_wdata  LSU -> mem  lane-replicated store data
//   mem_be     LSU -> mem  byte enables, bit i = byte lane i
//   mem_ack    mem -> LSU  request completes this cycle
//   mem_rdata  mem -> LSU  read word, valid with mem_ack on reads
// Modports: master (load/store unit side), slave (memory side).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage executing LOAD/STORE via a req/ack data bus
//
// Purpose: takes the ALU result as effective address and performs one byte,
//   halfword or word load/store per request. Stores get lane-replicated write
//   data and byte enables; loads are sign/zero extended from the addressed lane.
//   The core stalls while busy is high; done pulses for one cycle per operation.
// Parameters:
//   TIMEOUT_CYCLES  cycles spent waiting for mem_ack before the request is aborted
//   TO_W            width of the timeout counter
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request valid, only looked at in IDLE
//   opcode, funct3  instruction fields selecting LOAD/STORE and access size
//   addr            effective address
//   store_data      rs2 value for stores
//   busy            high whenever not IDLE
//   done, err       completion pulse and its error qualifier
//   rdata           extended load result, held until the next load completes
//   mem             load_store_unit_if master modport towards data memory
// Build option:
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses complete
//                     immediately with err=1 and never issue a memory request.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [6:0]                opcode,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               rdata,
  load_store_unit_if.master         mem
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Size field shared by loads and stores: funct3[1:0] = 00 byte, 01 half, 10 word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lo_q, lo_d;
  logic            is_load_q, is_load_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;

  logic            req_is_load;
  logic            req_is_store;
  logic            f3_legal;
  logic            misaligned;
  logic [3:0]      be_calc;
  logic [31:0]     wdata_calc;
  logic [31:0]     lane_word;
  logic [15:0]     lane_half;
  logic [31:0]     load_ext;

  // Request decode: size-derived byte enables and replicated write data.
  always_comb begin
    req_is_load  = (opcode == OP_LOAD);
    req_is_store = (opcode == OP_STORE);

    f3_legal = 1'b0;
    if (req_is_load) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end else if (req_is_store) begin
      f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end

`ifdef MISALIGN_TRAP_EN
    misaligned = ((funct3[1:0] == SZ_H) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif

    case (funct3[1:0])
      SZ_B:    be_calc = 4'b0001 << addr[1:0];
      SZ_H:    be_calc = 4'b0011 << {addr[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase

    case (funct3[1:0])
      SZ_B:    wdata_calc = {4{store_data[7:0]}};
      SZ_H:    wdata_calc = {2{store_data[15:0]}};
      default: wdata_calc = store_data;
    endcase
  end

  // Load extraction uses the captured size and low address bits, since the
  // core-side inputs may already have moved on while the request is pending.
  always_comb begin
    lane_word = mem.mem_rdata >> {lo_q, 3'b000};
    lane_half = lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_word[7:0]};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    lo_d        = lo_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (start && (req_is_load || req_is_store)) begin
          funct3_d  = funct3;
          lo_d      = addr[1:0];
          is_load_d = req_is_load;
          if (!f3_legal || misaligned) begin
            // Rejected before touching the bus: memory outputs keep their old values.
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_calc;
            mem_wdata_d = wdata_calc;
          end
        end
      end

      S_REQ: begin
        if (mem.mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          if (is_load_q) begin
            rdata_d = load_ext;
          end
        end else if (cnt_q == TO_LAST) begin
          // Last permitted wait cycle without ack: abort, rdata untouched.
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        err_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'b000;
      lo_q        <= 2'b00;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      lo_q        <= lo_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if mif ();

  load_store_unit #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns one cycle later (first REQ or DONE cycle).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    opcode = op; funct3 = f3; addr = a; store_data = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Immediate ack for one cycle; returns in the cycle after the ack.
  task automatic ack_now(input logic [31:0] rd);
    mif.mem_ack = 1'b1; mif.mem_rdata = rd;
    step();
    mif.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = 32'h0; store_data = 32'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    step(); step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy act=%0b exp=0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err act=%0b%0b exp=00", done, err); end
    checks++; if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0) begin failures++; $display("FAIL reset_req_we act=%0b%0b exp=00", mif.mem_req, mif.mem_we); end
    checks++; if (mif.mem_addr !== 32'h0 || mif.mem_wdata !== 32'h0 || rdata !== 32'h0) begin failures++; $display("FAIL reset_data act=%h/%h/%h exp=0", mif.mem_addr, mif.mem_wdata, rdata); end
    checks++; if (mif.mem_be !== 4'b0000) begin failures++; $display("FAIL reset_be act=%b exp=0000", mif.mem_be); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_word();
    issue(OP_STORE, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    checks++; if (mif.mem_req !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL sw_req act=%0b busy=%0b exp=1", mif.mem_req, busy); end
    checks++; if (mif.mem_addr !== 32'h104 || mif.mem_be !== 4'b1111) begin failures++; $display("FAIL sw_addr_be act=%h %b exp=00000104 1111", mif.mem_addr, mif.mem_be); end
    checks++; if (mif.mem_wdata !== 32'hDEADBEEF || mif.mem_we !== 1'b1) begin failures++; $display("FAIL sw_wdata_we act=%h %0b exp=deadbeef 1", mif.mem_wdata, mif.mem_we); end
    step();
    checks++; if (done !== 1'b0 || mif.mem_req !== 1'b1) begin failures++; $display("FAIL sw_wait1 act=done%0b req%0b exp=done0 req1", done, mif.mem_req); end
    step();
    checks++; if (done !== 1'b0 || mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h104) begin failures++; $display("FAIL sw_wait2 act=done%0b req%0b addr%h exp=done0 req1 addr00000104", done, mif.mem_req, mif.mem_addr); end
    ack_now(32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b0 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL sw_done act=done%0b err%0b req%0b exp=done1 err0 req0", done, err, mif.mem_req); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL sw_idle act=done%0b busy%0b exp=00", done, busy); end
  endtask

  task automatic test_load_ext();
    issue(OP_LOAD, 3'b000, 32'h0000_0203, 32'h0);
    checks++; if (mif.mem_be !== 4'b1000 || mif.mem_we !== 1'b0 || mif.mem_addr !== 32'h200) begin failures++; $display("FAIL lb_req act=be%b we%0b addr%h exp=be1000 we0 addr00000200", mif.mem_be, mif.mem_we, mif.mem_addr); end
    ack_now(32'h80FF_0000);
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data act=done%0b err%0b rdata%h exp=1 0 ffffff80", done, err, rdata); end
    step();
    issue(OP_LOAD, 3'b100, 32'h0000_0203, 32'h0);
    ack_now(32'h80FF_0000);
    checks++; if (done !== 1'b1 || rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data act=done%0b rdata%h exp=1 00000080", done, rdata); end
    step();
    issue(OP_LOAD, 3'b001, 32'h0000_0002, 32'h0);
    checks++; if (mif.mem_be !== 4'b1100) begin failures++; $display("FAIL lh_be act=%b exp=1100", mif.mem_be); end
    ack_now(32'h8001_1234);
    checks++; if (done !== 1'b1 || rdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data act=done%0b rdata%h exp=1 ffff8001", done, rdata); end
    step();
  endtask

  task automatic test_store_half_byte();
    issue(OP_STORE, 3'b001, 32'h0000_0010, 32'h1234_ABCD);
    checks++; if (mif.mem_be !== 4'b0011 || mif.mem_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_req act=be%b wdata%h exp=0011 abcdabcd", mif.mem_be, mif.mem_wdata); end
    ack_now(32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL sh_done act=done%0b err%0b exp=1 0", done, err); end
    step();
    issue(OP_STORE, 3'b000, 32'h0000_0003, 32'h7766_55A5);
    checks++; if (mif.mem_be !== 4'b1000 || mif.mem_wdata !== 32'hA5A5_A5A5 || mif.mem_addr !== 32'h0) begin failures++; $display("FAIL sb_req act=be%b wdata%h addr%h exp=1000 a5a5a5a5 00000000", mif.mem_be, mif.mem_wdata, mif.mem_addr); end
    ack_now(32'h0);
    step();
    issue(OP_LOAD, 3'b101, 32'h0000_0012, 32'h0);
    checks++; if (mif.mem_be !== 4'b1100 || mif.mem_addr !== 32'h10) begin failures++; $display("FAIL lhu_req act=be%b addr%h exp=1100 00000010", mif.mem_be, mif.mem_addr); end
    ack_now(32'hBEEF_0000);
    checks++; if (done !== 1'b1 || rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_data act=done%0b rdata%h exp=1 0000beef", done, rdata); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    issue(OP_LOAD, 3'b010, 32'h0000_0040, 32'h0);
    while (mif.mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n != 16) begin failures++; $display("FAIL to_req_cycles act=%0d exp=16", n); end
    checks++; if (done !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL to_done_err act=done%0b err%0b exp=1 1", done, err); end
    checks++; if (rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL to_rdata_held act=%h exp=0000beef", rdata); end
    step();
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL to_idle act=busy%0b err%0b exp=0 0", busy, err); end
  endtask

  task automatic test_illegal();
    issue(OP_LOAD, 3'b011, 32'h0000_0020, 32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL ill_load act=done%0b err%0b req%0b exp=1 1 0", done, err, mif.mem_req); end
    step();
    issue(OP_STORE, 3'b100, 32'h0000_0020, 32'h0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL ill_store act=done%0b err%0b req%0b exp=1 1 0", done, err, mif.mem_req); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ill_idle act=busy%0b done%0b exp=0 0", busy, done); end
  endtask

  task automatic test_misalign();
    issue(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checks++; if (done !== 1'b1 || err !== 1'b1 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL mis_trap act=done%0b err%0b req%0b exp=1 1 0", done, err, mif.mem_req); end
    step();
`else
    checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100 || mif.mem_be !== 4'b1111) begin failures++; $display("FAIL mis_req act=req%0b addr%h be%b exp=1 00000100 1111", mif.mem_req, mif.mem_addr, mif.mem_be); end
    ack_now(32'h1122_3344);
    checks++; if (done !== 1'b1 || err !== 1'b0 || rdata !== 32'h1122_3344) begin failures++; $display("FAIL mis_done act=done%0b err%0b rdata%h exp=1 0 11223344", done, err, rdata); end
    step();
`endif
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mis_idle act=%0b exp=0", busy); end
  endtask

  task automatic test_abort_and_ignore();
    issue(OP_LOAD, 3'b010, 32'h0000_0080, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || mif.mem_req !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_abort act=busy%0b req%0b done%0b exp=0 0 0", busy, mif.mem_req, done); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_no_done act=%0b exp=0", done); end
    issue(OP_ALU, 3'b010, 32'h0000_0500, 32'h0);
    checks++; if (busy !== 1'b0 || mif.mem_req !== 1'b0) begin failures++; $display("FAIL alu_ignored act=busy%0b req%0b exp=0 0", busy, mif.mem_req); end
    ack_now(32'h5555_5555);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL idle_ack act=busy%0b done%0b rdata%h exp=0 0 00000000", busy, done, rdata); end
    issue(OP_LOAD, 3'b010, 32'h0000_0300, 32'h0);
    opcode = OP_STORE; funct3 = 3'b010; addr = 32'h0000_0400; store_data = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (mif.mem_addr !== 32'h300 || mif.mem_we !== 1'b0 || mif.mem_req !== 1'b1) begin failures++; $display("FAIL req_start_ignored act=addr%h we%0b req%0b exp=00000300 0 1", mif.mem_addr, mif.mem_we, mif.mem_req); end
    ack_now(32'hCAFE_F00D);
    checks++; if (done !== 1'b1 || rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL req_start_done act=done%0b rdata%h exp=1 cafef00d", done, rdata); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL final_idle act=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_store_half_byte();
    test_timeout();
    test_illegal();
    test_misalign();
    test_abort_and_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
